// File: rtl/bus_transfer_arbiter.sv
// ---------------------------------------------------------------------------
// bus_transfer_arbiter
//
// Round-robin arbiter and sequencer for the shared 32-bit internal CPU bus.
// Each requester asks for one register-to-register transfer (5-bit source
// code, 5-bit destination code). The winner's codes are latched at grant,
// the source select is driven to the bus multiplexer, and after a settle
// cycle the destination load enable and the requester's ack are pulsed.
// Only one transfer is in flight at a time.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous, active-high reset
//   req        - per-requester transfer request (level)
//   src_code   - packed source codes, requester i uses bits [5i+4:5i]
//   dst_code   - packed destination codes, same packing
//   bus_select - select to the bus multiplexer (holds its value when idle)
//   dst_load   - one-hot destination load enable, single-cycle pulse
//   ack        - one-hot transfer-complete pulse to the winning requester
//   err        - single-cycle pulse when the latched codes are illegal
//   busy       - high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module bus_transfer_arbiter #(
    parameter int N_REQ = 4,
    parameter int N_SRC = 24,
    parameter int N_DST = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [5*N_REQ-1:0]   src_code,
    input  logic [5*N_REQ-1:0]   dst_code,
    output logic [4:0]           bus_select,
    output logic [N_DST-1:0]     dst_load,
    output logic [N_REQ-1:0]     ack,
    output logic                 err,
    output logic                 busy
);

    localparam int PTR_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        LOAD
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] winner;
    logic [4:0]       latched_src;
    logic [4:0]       latched_dst;

    logic [PTR_W-1:0] next_ptr;
    logic [PTR_W-1:0] arb_ptr;
    logic [PTR_W-1:0] cand;
    logic [PTR_W-1:0] grant_idx;
    logic [N_REQ-1:0] winner_onehot;
    logic [N_REQ-1:0] arb_req;
    logic             grant_valid;
    logic [4:0]       grant_src;
    logic [4:0]       grant_dst;
    logic             codes_legal;
    logic [N_DST-1:0] dst_onehot;

    // In LOAD the next arbitration must already see the advanced pointer and
    // must ignore the current winner's request, whose ack is only now being
    // issued; otherwise a requester still holding req would be re-granted.
    always_comb begin
        winner_onehot = N_REQ'(1) << winner;
        next_ptr      = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
        if (state == LOAD) begin
            arb_req = req & ~winner_onehot;
            arb_ptr = next_ptr;
        end else begin
            arb_req = req;
            arb_ptr = rr_ptr;
        end
    end

    // Round-robin search: first set request at or above the pointer,
    // wrapping. Scanning from the farthest candidate down lets the nearest
    // one overwrite the result last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = PTR_W'((int'(arb_ptr) + k) % N_REQ);
            if (arb_req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Select the winner's codes out of the packed input buses.
    always_comb begin
        grant_src = '0;
        grant_dst = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                grant_src = src_code[5*i +: 5];
                grant_dst = dst_code[5*i +: 5];
            end
        end
    end

    // Legality of the latched transfer and the decoded load enable.
    always_comb begin
        codes_legal = (int'(latched_src) < N_SRC) && (int'(latched_dst) < N_DST);
        dst_onehot  = N_DST'(1) << latched_dst;
    end

    // Sequencer. bus_select changes only on the DRIVE->LOAD edge, so during
    // the cycle the load pulse is visible the mux still carries this
    // transfer's source, even when the next transfer is already in DRIVE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            winner      <= '0;
            latched_src <= '0;
            latched_dst <= '0;
            bus_select  <= '0;
            dst_load    <= '0;
            ack         <= '0;
            err         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            dst_load <= '0;
            ack      <= '0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        winner      <= grant_idx;
                        latched_src <= grant_src;
                        latched_dst <= grant_dst;
                        state       <= DRIVE;
                        busy        <= 1'b1;
                    end
                end
                DRIVE: begin
                    bus_select <= latched_src;
                    state      <= LOAD;
                end
                LOAD: begin
                    if (codes_legal) begin
                        dst_load <= dst_onehot;
                    end else begin
                        err <= 1'b1;
                    end
                    ack    <= winner_onehot;
                    rr_ptr <= next_ptr;
                    if (grant_valid) begin
                        winner      <= grant_idx;
                        latched_src <= grant_src;
                        latched_dst <= grant_dst;
                        state       <= DRIVE;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_transfer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_transfer_arbiter
//
// Self-checking bench for bus_transfer_arbiter (N_REQ=4, N_SRC=24, N_DST=24).
// Single transfers come from a table of hand-computed vectors; round robin,
// pointer wrap, reset abort and code change after grant are hand sequences.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_bus_transfer_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req;
    logic [19:0] src_code;
    logic [19:0] dst_code;
    logic [4:0]  bus_select;
    logic [23:0] dst_load;
    logic [3:0]  ack;
    logic        err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  req;
        int          idx;
        logic [4:0]  src;
        logic [4:0]  dst;
        logic [4:0]  exp_bus;
        logic [23:0] exp_load;
        logic [3:0]  exp_ack;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    bus_transfer_arbiter #(
        .N_REQ(4),
        .N_SRC(24),
        .N_DST(24)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .src_code  (src_code),
        .dst_code  (dst_code),
        .bus_select(bus_select),
        .dst_load  (dst_load),
        .ack       (ack),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Structural invariants on every sampled cycle outside reset.
    always @(negedge clk) begin
        if (!reset) begin
            n_checks++;
            if (!$onehot0(dst_load) || !$onehot0(ack) || (dst_load != '0 && ack == '0)) begin
                n_fail++;
                $display("[TB] FAIL invariant: dst_load=%h ack=%b, required one-hot-or-zero and load only with ack",
                         dst_load, ack);
            end
        end
    end

    // Safety net so the run always ends.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Place one requester's codes; all other slots carry the illegal code 31.
    task automatic setCodes(input int idx, input logic [4:0] src, input logic [4:0] dst);
        src_code = (20'hFFFFF & ~(20'h1F << (5*idx))) | (20'(src) << (5*idx));
        dst_code = (20'hFFFFF & ~(20'h1F << (5*idx))) | (20'(dst) << (5*idx));
    endtask

    task automatic doReset();
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One isolated transfer from IDLE: grant, drive, load pulse, back to idle.
    task automatic applyStimulus(input int n, input vec_t v);
        setCodes(v.idx, v.src, v.dst);
        req = v.req;
        @(negedge clk);
        checkOutput($sformatf("vec%0d_busy_grant", n), busy, 1);
        checkOutput($sformatf("vec%0d_ack_early", n), ack, 0);
        @(negedge clk);
        checkOutput($sformatf("vec%0d_bus_drive", n), bus_select, v.exp_bus);
        checkOutput($sformatf("vec%0d_load_early", n), dst_load, 0);
        @(negedge clk);
        checkOutput($sformatf("vec%0d_dst_load", n), dst_load, v.exp_load);
        checkOutput($sformatf("vec%0d_ack", n), ack, v.exp_ack);
        checkOutput($sformatf("vec%0d_err", n), err, v.exp_err);
        checkOutput($sformatf("vec%0d_bus_load", n), bus_select, v.exp_bus);
        req = '0;
        @(negedge clk);
        checkOutput($sformatf("vec%0d_pulse_end", n), {ack, dst_load, err}, 0);
        checkOutput($sformatf("vec%0d_busy_idle", n), busy, 0);
        checkOutput($sformatf("vec%0d_bus_hold", n), bus_select, v.exp_bus);
    endtask

    initial begin
        int   ack_count;
        int   exp_idx;
        logic busy_ok;
        logic saw_activity;

        vecs[0] = '{4'b0001, 0, 5'd5,  5'd2,  5'd5,  24'h000004, 4'b0001, 1'b0};
        vecs[1] = '{4'b0010, 1, 5'd23, 5'd23, 5'd23, 24'h800000, 4'b0010, 1'b0};
        vecs[2] = '{4'b0100, 2, 5'd0,  5'd0,  5'd0,  24'h000001, 4'b0100, 1'b0};
        vecs[3] = '{4'b1000, 3, 5'd24, 5'd3,  5'd24, 24'h000000, 4'b1000, 1'b1};
        vecs[4] = '{4'b0001, 0, 5'd7,  5'd24, 5'd7,  24'h000000, 4'b0001, 1'b1};
        vecs[5] = '{4'b0010, 1, 5'd30, 5'd31, 5'd30, 24'h000000, 4'b0010, 1'b1};
        vecs[6] = '{4'b0100, 2, 5'd12, 5'd17, 5'd12, 24'h020000, 4'b0100, 1'b0};

        req      = '0;
        src_code = '1;
        dst_code = '1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_bus_select", bus_select, 0);
        checkOutput("reset_dst_load", dst_load, 0);
        checkOutput("reset_ack", ack, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_no_req_busy", busy, 0);

        $display("[TB] single transfers from table");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Last vector granted requester 2, so the pointer now sits at 3.
        $display("[TB] pointer wrap with req=1001");
        src_code = {5'd14, 5'd31, 5'd31, 5'd9};
        dst_code = {5'd6,  5'd31, 5'd31, 5'd4};
        req = 4'b1001;
        @(negedge clk);
        @(negedge clk);
        checkOutput("wrap_bus_first", bus_select, 14);
        @(negedge clk);
        checkOutput("wrap_ack_first", ack, 4'b1000);
        checkOutput("wrap_load_first", dst_load, 24'h000040);
        req = 4'b0001;
        @(negedge clk);
        checkOutput("wrap_bus_second", bus_select, 9);
        checkOutput("wrap_busy_between", busy, 1);
        @(negedge clk);
        checkOutput("wrap_ack_second", ack, 4'b0001);
        checkOutput("wrap_load_second", dst_load, 24'h000010);
        req = '0;
        @(negedge clk);
        checkOutput("wrap_busy_idle", busy, 0);

        $display("[TB] round robin with all requesters held");
        doReset();
        src_code = {5'd4,  5'd3,  5'd2, 5'd1};
        dst_code = {5'd11, 5'd10, 5'd9, 5'd8};
        req = 4'b1111;
        ack_count = 0;
        busy_ok   = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (ack != '0) begin
                if (ack_count < 6) begin
                    exp_idx = ack_count % 4;
                    checkOutput($sformatf("rr_ack%0d", ack_count), ack, 4'b0001 << exp_idx);
                    checkOutput($sformatf("rr_load%0d", ack_count), dst_load, 24'h000001 << (exp_idx + 8));
                    checkOutput($sformatf("rr_bus%0d", ack_count), bus_select, exp_idx + 1);
                    checkOutput($sformatf("rr_cycle%0d", ack_count), c, 3 + 2*ack_count);
                end
                ack_count++;
            end
        end
        checkOutput("rr_ack_count", ack_count, 6);
        checkOutput("rr_busy_held", busy_ok, 1);
        // Requester 2 was already granted; dropping req must not cancel it.
        req = '0;
        @(negedge clk);
        checkOutput("rr_drop_busy", busy, 1);
        checkOutput("rr_drop_ack_early", ack, 0);
        @(negedge clk);
        checkOutput("rr_drop_ack", ack, 4'b0100);
        checkOutput("rr_drop_load", dst_load, 24'h000400);
        checkOutput("rr_drop_busy_idle", busy, 0);

        $display("[TB] reset during DRIVE");
        setCodes(0, 5'd5, 5'd2);
        req = 4'b0001;
        @(negedge clk);
        checkOutput("abort_busy_drive", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_bus_select", bus_select, 0);
        checkOutput("abort_outputs", {ack, dst_load, err, busy}, 0);
        reset = 1'b0;
        req   = '0;
        saw_activity = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ack != '0 || dst_load != '0 || busy) saw_activity = 1'b1;
        end
        checkOutput("abort_no_load_ack", saw_activity, 0);

        $display("[TB] code change after grant");
        setCodes(1, 5'd11, 5'd5);
        req = 4'b0010;
        @(negedge clk);
        setCodes(1, 5'd19, 5'd9);
        @(negedge clk);
        checkOutput("latch_bus_drive", bus_select, 11);
        @(negedge clk);
        checkOutput("latch_bus_load", bus_select, 11);
        checkOutput("latch_dst_load", dst_load, 24'h000020);
        checkOutput("latch_ack", ack, 4'b0010);
        checkOutput("latch_err", err, 0);
        req = '0;
        @(negedge clk);
        checkOutput("latch_busy_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
